// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_PIPE,
        WB_SRC_LU
    } wb_src_e;

    typedef enum logic {
        ARB_NORMAL,
        ARB_FORCE_LU
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard for long-latency ops: issue gating and decode hazards.
module wb_scoreboard
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    output logic              issue_ready,
    input  logic              clr_valid,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    output logic              hazard_stall
);

    localparam int unsigned CNT_W = 6;

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic                set_en;
    logic                clr_en;

    // Readiness looks only at pre-update state, so a same-cycle retire cannot unblock.
    assign issue_ready = !pending[issue_rd] && (count < CNT_W'(MAX_OUTSTANDING));
    assign set_en      = issue_valid && issue_ready && (issue_rd != REG_ZERO);
    assign clr_en      = clr_valid && (clr_rd != REG_ZERO) && pending[clr_rd];

    assign hazard_stall = ((dec_rs1 != REG_ZERO) && pending[dec_rs1]) ||
                          ((dec_rs2 != REG_ZERO) && pending[dec_rs2]) ||
                          ((dec_rd  != REG_ZERO) && pending[dec_rd]);

    // set requires !pending and clear requires pending, so they never hit the same bit.
    always_comb begin
        pending_next = pending;
        count_next   = count;
        if (clr_en) begin
            pending_next[clr_rd] = 1'b0;
            count_next           = count_next - CNT_W'(1);
        end
        if (set_en) begin
            pending_next[issue_rd] = 1'b1;
            count_next             = count_next + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            count   <= '0;
        end else begin
            pending <= pending_next;
            count   <= count_next;
        end
    end

    // Issuing into a blocked scoreboard is a protocol violation and is dropped.
    property p_issue_legal;
        @(posedge clk) disable iff (rst) issue_valid |-> issue_ready;
    endproperty
    a_issue_legal: assert property (p_issue_legal);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and a
// buffered long-latency unit result, with starvation-forced pipeline stall.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX      = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_rd,
    input  logic [XLEN-1:0]   pipe_wd,
    output logic              pipe_stall,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [XLEN-1:0]   lu_wd,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    output logic              issue_ready,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    output logic              hazard_stall,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_wd
);

    localparam int unsigned WAIT_W = 4;

    arb_state_e        state;
    arb_state_e        state_next;
    wb_src_e           src;
    wb_req_t           pipe_req;
    wb_req_t           lu_buf;
    wb_req_t           wb_next;
    logic              lu_buf_v;
    logic              drain;
    logic              lu_load;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;

    // The buffer's we bit doubles as its valid flag.
    assign lu_buf_v = lu_buf.we;

    always_comb begin
        pipe_req.we = pipe_we && (pipe_rd != REG_ZERO);
        pipe_req.rd = pipe_rd;
        pipe_req.wd = pipe_wd;
    end

    // Grant and next-state.
    always_comb begin
        src        = WB_SRC_NONE;
        state_next = state;
        case (state)
            ARB_FORCE_LU: begin
                if (lu_buf_v) begin
                    src = WB_SRC_LU;
                end
                state_next = ARB_NORMAL;
            end
            default: begin
                if (pipe_req.we) begin
                    src = WB_SRC_PIPE;
                end else if (lu_buf_v) begin
                    src = WB_SRC_LU;
                end
                if (lu_buf_v && (src == WB_SRC_PIPE) &&
                    (wait_cnt == WAIT_W'(STARVE_MAX - 1))) begin
                    state_next = ARB_FORCE_LU;
                end
            end
        endcase
    end

    assign drain    = (src == WB_SRC_LU);
    assign lu_ready = !lu_buf_v || drain;
    assign lu_load  = lu_valid && lu_ready && (lu_rd != REG_ZERO);

    always_comb begin
        wait_next = wait_cnt;
        if (!lu_buf_v || drain) begin
            wait_next = '0;
        end else if (wait_cnt < WAIT_W'(STARVE_MAX)) begin
            wait_next = wait_cnt + WAIT_W'(1);
        end
    end

    always_comb begin
        wb_next = '0;
        case (src)
            WB_SRC_PIPE: wb_next = pipe_req;
            WB_SRC_LU:   wb_next = lu_buf;
            default:     wb_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_NORMAL;
            pipe_stall <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_next;
            pipe_stall <= (state_next == ARB_FORCE_LU);
            wait_cnt   <= wait_next;
        end
    end

    // Single-entry long-unit result buffer; rd==0 results are accepted and dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_buf <= '0;
        end else if (lu_load) begin
            lu_buf.we <= 1'b1;
            lu_buf.rd <= lu_rd;
            lu_buf.wd <= lu_wd;
        end else if (drain) begin
            lu_buf.we <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_a3 <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= wb_next.we;
            rf_a3 <= wb_next.rd;
            rf_wd <= wb_next.wd;
        end
    end

    wb_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .clr_valid    (drain),
        .clr_rd       (lu_buf.rd),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .hazard_stall (hazard_stall)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        pipe_stall;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wd;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        hazard_stall;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    wb_port_arbiter #(
        .STARVE_MAX      (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_rd      (pipe_rd),
        .pipe_wd      (pipe_wd),
        .pipe_stall   (pipe_stall),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_rd        (lu_rd),
        .lu_wd        (lu_wd),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .hazard_stall (hazard_stall),
        .rf_we        (rf_we),
        .rf_a3        (rf_a3),
        .rf_wd        (rf_wd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Pipe writes every cycle while a long-unit result (lrd/lwd) sits in the buffer.
    // Pipe wins 4 cycles, then one forced cycle writes the buffer, then the held bundle.
    task automatic starve_seq(input logic [4:0] lrd, input logic [31:0] lwd,
                              input logic [4:0] prd0, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            int p;
            p        = (i < 6) ? i : 5;
            pipe_we  = 1'b1;
            pipe_rd  = prd0 + 5'(p);
            pipe_wd  = 32'h100 + 32'(p);
            lu_valid = (i == 0);
            lu_rd    = lrd;
            lu_wd    = lwd;
            tick();
            lu_valid = 1'b0;
            check($sformatf("starve_we[%0d]", i), 32'(rf_we), 32'd1);
            if (i == 5) begin
                check("starve_lu_a3", 32'(rf_a3), 32'(lrd));
                check("starve_lu_wd", rf_wd, lwd);
            end else begin
                check($sformatf("starve_a3[%0d]", i), 32'(rf_a3), 32'(prd0 + 5'(p)));
                check($sformatf("starve_wd[%0d]", i), rf_wd, 32'h100 + 32'(p));
            end
            check($sformatf("starve_stall[%0d]", i), 32'(pipe_stall), (i == 4) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        pipe_we = 1'b0; pipe_rd = '0; pipe_wd = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_wd = '0;
        issue_valid = 1'b0; issue_rd = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;

        // Reset values
        settle();
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_a3", 32'(rf_a3), 32'd0);
        check("rst_rf_wd", rf_wd, 32'd0);
        check("rst_stall", 32'(pipe_stall), 32'd0);
        tick();
        tick();
        check("rst_rf_we_held", 32'(rf_we), 32'd0);
        rst = 1'b0;

        // Plain pipeline writeback, 1-cycle latency
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'hDEADBEEF;
        tick();
        pipe_we = 1'b0;
        check("pipe_we", 32'(rf_we), 32'd1);
        check("pipe_a3", 32'(rf_a3), 32'd5);
        check("pipe_wd", rf_wd, 32'hDEADBEEF);
        tick();
        check("pipe_idle_we", 32'(rf_we), 32'd0);

        // Issue rd=7, return its result, watch the hazard window
        issue_valid = 1'b1; issue_rd = 5'd7; dec_rs1 = 5'd7;
        settle();
        check("iss7_ready", 32'(issue_ready), 32'd1);
        check("iss7_haz_pre", 32'(hazard_stall), 32'd0);
        tick();
        issue_valid = 1'b0;
        settle();
        check("iss7_haz_pend", 32'(hazard_stall), 32'd1);
        lu_valid = 1'b1; lu_rd = 5'd7; lu_wd = 32'h1234;
        settle();
        check("lu7_ready", 32'(lu_ready), 32'd1);
        tick();
        lu_valid = 1'b0;
        settle();
        check("lu7_accept_we", 32'(rf_we), 32'd0);
        check("lu7_haz_buf", 32'(hazard_stall), 32'd1);
        tick();
        check("lu7_we", 32'(rf_we), 32'd1);
        check("lu7_a3", 32'(rf_a3), 32'd7);
        check("lu7_wd", rf_wd, 32'h1234);
        check("lu7_haz_clr", 32'(hazard_stall), 32'd0);
        dec_rs1 = '0;

        // Starvation: buffer rd=9, pipe writes every cycle
        starve_seq(5'd9, 32'h99, 5'd10, 7);
        pipe_we = 1'b0;
        tick();
        check("starve_after_we", 32'(rf_we), 32'd0);

        // Pipe with rd=0 never claims the port
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wd = 32'hBAD;
        lu_valid = 1'b1; lu_rd = 5'd3; lu_wd = 32'h33;
        tick();
        lu_valid = 1'b0;
        check("rd0_load_we", 32'(rf_we), 32'd0);
        tick();
        check("rd0_lu_we", 32'(rf_we), 32'd1);
        check("rd0_lu_a3", 32'(rf_a3), 32'd3);
        check("rd0_lu_wd", rf_wd, 32'h33);
        check("rd0_wait", 32'(dut.wait_cnt), 32'd0);
        check("rd0_stall", 32'(pipe_stall), 32'd0);
        pipe_we = 1'b0;

        // Outstanding limit
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            settle();
            check($sformatf("fill_ready[%0d]", r), 32'(issue_ready), 32'd1);
            tick();
        end
        issue_valid = 1'b0; issue_rd = 5'd5;
        settle();
        check("full_ready", 32'(issue_ready), 32'd0);
        issue_rd = 5'd2;
        settle();
        check("dup_ready", 32'(issue_ready), 32'd0);
        dec_rd = 5'd4;
        settle();
        check("waw_haz", 32'(hazard_stall), 32'd1);
        dec_rd = 5'd0;
        settle();
        check("x0_haz", 32'(hazard_stall), 32'd0);
        issue_rd = 5'd5;
        lu_valid = 1'b1; lu_rd = 5'd1; lu_wd = 32'h11;
        tick();
        lu_valid = 1'b0;
        settle();
        check("retire_same_cyc", 32'(issue_ready), 32'd0);
        tick();
        check("retire_a3", 32'(rf_a3), 32'd1);
        settle();
        check("retire_ready", 32'(issue_ready), 32'd1);

        // Reset in the middle of a forced drain
        dec_rs1 = 5'd3;
        starve_seq(5'd2, 32'h22, 5'd20, 5);
        pipe_we = 1'b0;
        settle();
        check("prerst_haz", 32'(hazard_stall), 32'd1);
        rst = 1'b1;
        settle();
        check("midrst_we", 32'(rf_we), 32'd0);
        check("midrst_stall", 32'(pipe_stall), 32'd0);
        check("midrst_haz", 32'(hazard_stall), 32'd0);
        issue_rd = 5'd2;
        settle();
        check("midrst_ready", 32'(issue_ready), 32'd1);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("postrst_we[%0d]", k), 32'(rf_we), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
